// File: rtl/count_done_monitor.sv
// count_done_monitor
//   Downstream monitor for a selector-gated 8-bit up-counter (x, y, size).
//   Each cycle it samples x/y/size, counts the increment steps the counter
//   takes, detects the terminal condition x > size and presents a single
//   completion record on a valid/ready port.  In parallel it checks the
//   counter's invariants and raises a sticky error flag on any violation.
//
//   Optional feature (macro STALL_WDOG_EN): a stall watchdog that sets a
//   sticky stall_flag after STALL_LIMIT consecutive idle cycles in RUN.
//   Without the macro no watchdog logic is built and stall_flag is tied 0.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high
//   selector_in  selector driven into the counter
//   x_in         counter x
//   y_in         counter y
//   size_in      counter size bound
//   done_valid   completion record valid
//   done_ready   consumer accepts the record
//   done_cycles  number of increment steps seen (saturating)
//   done_y       y at the terminal sample
//   inv_err      sticky invariant violation
//   stall_flag   sticky watchdog flag
//   state_o      FSM state: 0 IDLE, 1 RUN, 2 REPORT, 3 HALT
//
// Handshake: the record transfers on a rising edge where done_valid and
// done_ready are both 1.  Once done_valid is raised it stays 1, with
// done_cycles/done_y stable, until that transfer; done_valid does not
// depend combinationally on done_ready.
module count_done_monitor #(
   parameter int DATA_W      = 8,
   parameter int CNT_W       = 16,
   parameter int STALL_LIMIT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              selector_in,
   input  logic [DATA_W-1:0] x_in,
   input  logic [DATA_W-1:0] y_in,
   input  logic [DATA_W-1:0] size_in,
   output logic              done_valid,
   input  logic              done_ready,
   output logic [CNT_W-1:0]  done_cycles,
   output logic [DATA_W-1:0] done_y,
   output logic              inv_err,
   output logic              stall_flag,
   output logic [1:0]        state_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_REPORT = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    step_cnt_q, step_cnt_d;
   logic [CNT_W-1:0]    done_cycles_q, done_cycles_d;
   logic [DATA_W-1:0]   done_y_q, done_y_d;
   logic                inv_err_q;

   logic [DATA_W-1:0]   prev_x_q;
   logic [DATA_W-1:0]   prev_size_q;
   logic                prev_step_q;
   logic                prev_vld_q;

   logic                step;
   logic                term;
   logic [CNT_W-1:0]    step_cnt_inc;
   logic [DATA_W-1:0]   y_plus1;
   logic [DATA_W-1:0]   x_pred;
   logic                inv_fail;

   // step and term are mutually exclusive: step needs x <= size.
   assign step = selector_in && (x_in <= size_in);
   assign term = (x_in > size_in);

   assign step_cnt_inc = (step_cnt_q == {CNT_W{1'b1}}) ? step_cnt_q
                                                       : step_cnt_q + 1'b1;

   // Invariants: y trails x by one; size never changes; x advances exactly
   // by the previous cycle's step (wrapping at DATA_W bits).
   assign y_plus1  = y_in + 1'b1;
   assign x_pred   = prev_x_q + DATA_W'(prev_step_q);
   assign inv_fail = (x_in != y_plus1) ||
                     (prev_vld_q && ((size_in != prev_size_q) || (x_in != x_pred)));

   // Next-state / datapath logic
   always_comb begin
      state_d       = state_q;
      step_cnt_d    = step_cnt_q;
      done_cycles_d = done_cycles_q;
      done_y_d      = done_y_q;
      case (state_q)
         ST_IDLE: begin
            if (term) begin
               state_d       = ST_REPORT;
               done_cycles_d = step_cnt_q;
               done_y_d      = y_in;
            end else if (step) begin
               state_d    = ST_RUN;
               step_cnt_d = step_cnt_inc;
            end
         end
         ST_RUN: begin
            if (term) begin
               state_d       = ST_REPORT;
               done_cycles_d = step_cnt_q;
               done_y_d      = y_in;
            end else if (step) begin
               step_cnt_d = step_cnt_inc;
            end
         end
         ST_REPORT: begin
            if (done_ready) begin
               state_d = ST_HALT;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         step_cnt_q    <= '0;
         done_cycles_q <= '0;
         done_y_q      <= '0;
         inv_err_q     <= 1'b0;
         prev_x_q      <= '0;
         prev_size_q   <= '0;
         prev_step_q   <= 1'b0;
         prev_vld_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         step_cnt_q    <= step_cnt_d;
         done_cycles_q <= done_cycles_d;
         done_y_q      <= done_y_d;
         if (inv_fail) begin
            inv_err_q <= 1'b1;
         end
         prev_x_q      <= x_in;
         prev_size_q   <= size_in;
         prev_step_q   <= step;
         prev_vld_q    <= 1'b1;
      end
   end

`ifdef STALL_WDOG_EN
   localparam int IDLE_W = $clog2(STALL_LIMIT + 1);

   logic [IDLE_W-1:0] idle_cnt_q;
   logic              stall_q;

   // Counts consecutive selector-low cycles while in RUN; the flag is set
   // on the edge that samples the STALL_LIMIT-th idle cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_q <= '0;
         stall_q    <= 1'b0;
      end else if (state_q != ST_RUN) begin
         idle_cnt_q <= '0;
      end else if (selector_in) begin
         idle_cnt_q <= '0;
      end else if (idle_cnt_q >= IDLE_W'(STALL_LIMIT - 1)) begin
         idle_cnt_q <= IDLE_W'(STALL_LIMIT - 1);
         stall_q    <= 1'b1;
      end else begin
         idle_cnt_q <= idle_cnt_q + 1'b1;
      end
   end

   assign stall_flag = stall_q;
`else
   assign stall_flag = 1'b0;
`endif

   assign done_valid  = (state_q == ST_REPORT);
   assign done_cycles = done_cycles_q;
   assign done_y      = done_y_q;
   assign inv_err     = inv_err_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_count_done_monitor.sv
module tb_count_done_monitor;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 16;

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              rst;
   logic              sel;
   logic [DATA_W-1:0] x_in, y_in, size_in;
   logic              done_valid, done_ready;
   logic [CNT_W-1:0]  done_cycles;
   logic [DATA_W-1:0] done_y;
   logic              inv_err, stall_flag;
   logic [1:0]        state_o;

   always #5 clk = ~clk;

   count_done_monitor #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .STALL_LIMIT(8)
   ) dut (
      .clk(clk), .rst(rst), .selector_in(sel),
      .x_in(x_in), .y_in(y_in), .size_in(size_in),
      .done_valid(done_valid), .done_ready(done_ready),
      .done_cycles(done_cycles), .done_y(done_y),
      .inv_err(inv_err), .stall_flag(stall_flag), .state_o(state_o)
   );

   int checks = 0;
   int errors = 0;

`ifdef STALL_WDOG_EN
   localparam logic EXP_STALL = 1'b1;
`else
   localparam logic EXP_STALL = 1'b0;
`endif

   // ---------------- scoreboard helper ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic s, input logic rdy,
                        input logic [7:0] x, input logic [7:0] y, input logic [7:0] sz);
      rst = r; sel = s; done_ready = rdy; x_in = x; y_in = y; size_in = sz;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 8'd230);
      tick();
      rst = 1'b0;
   endtask

   // Drives a model counter x=1,y=0,size=230 until the terminal sample,
   // holds done_ready low for 'hold' cycles, then accepts the record.
   // toggle: selector 1,0,1,0...; jump_x: when a step is taken at this x,
   // the counter jumps by 3 instead of 1 (0 = no jump).
   task automatic run_seq(input string nm, input bit toggle, input int hold, input int jump_x);
      logic [7:0] cx, cy;
      logic       s, was_term, did_step;
      int         steps, cyc;
      bit         early_valid, jump_pending, jumped, unstable;
      do_reset();
      cx = 8'd1; cy = 8'd0; steps = 0; cyc = 0;
      was_term = 1'b0; early_valid = 0; jump_pending = 0; jumped = 0;
      while (!was_term && cyc < 1000) begin
         s = toggle ? ((cyc % 2) == 0) : 1'b1;
         drive(1'b0, s, 1'b0, cx, cy, 8'd230);
         was_term = (cx > 8'd230);
         did_step = s && (cx <= 8'd230);
         tick();
         cyc++;
         if (!was_term && done_valid) early_valid = 1;
         if (jump_pending) begin
            chk({nm, "_inv_after_jump"}, inv_err, 1);
            jump_pending = 0;
         end
         if (did_step) begin
            steps++;
            if (jump_x != 0 && cx == jump_x[7:0]) begin
               chk({nm, "_inv_before_jump"}, inv_err, 0);
               cx = cx + 8'd3;
               jump_pending = 1;
               jumped = 1;
            end else begin
               cx = cx + 8'd1;
            end
            cy = cx - 8'd1;
         end
      end
      chk({nm, "_term_reached"}, was_term, 1);
      chk({nm, "_no_early_valid"}, early_valid, 0);
      chk({nm, "_valid"}, done_valid, 1);
      chk({nm, "_state_report"}, state_o, 2);
      chk({nm, "_cycles_model"}, done_cycles, steps);
      chk({nm, "_cycles"}, done_cycles, jumped ? (230 - 2) : 230);
      chk({nm, "_y"}, done_y, 230);
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (!done_valid || done_cycles != steps[15:0] || done_y != 8'd230 || state_o != 2'd2)
            unstable = 1;
      end
      if (hold > 0) chk({nm, "_held_stable"}, unstable, 0);
      done_ready = 1'b1;
      tick();
      chk({nm, "_valid_drop"}, done_valid, 0);
      chk({nm, "_state_halt"}, state_o, 3);
      tick();
      chk({nm, "_halt_stays"}, state_o, 3);
      chk({nm, "_halt_y"}, done_y, 230);
      chk({nm, "_inv"}, inv_err, jumped ? 1 : 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        r, s, rdy;
      logic [7:0]  x, y, sz;
      logic        e_valid;
      logic [15:0] e_cycles;
      logic [7:0]  e_y;
      logic        e_inv;
      logic [1:0]  e_state;
   } vec_t;

   vec_t vecs[15];

   initial begin
      //            r  s  rdy  x   y   sz  valid cyc y  inv st
      vecs[0]  = '{1, 0, 0,  1,  0,  0,  0,  0, 0, 0, 0}; // reset
      vecs[1]  = '{0, 1, 0,  1,  0,  0,  1,  0, 0, 0, 2}; // size 0: IDLE -> REPORT
      vecs[2]  = '{0, 1, 0,  1,  0,  0,  1,  0, 0, 0, 2}; // held, no ready
      vecs[3]  = '{0, 1, 1,  1,  0,  0,  0,  0, 0, 0, 3}; // accepted -> HALT
      vecs[4]  = '{0, 1, 1,  1,  0,  0,  0,  0, 0, 0, 3}; // HALT absorbing
      vecs[5]  = '{1, 0, 0,  1,  0,  0,  0,  0, 0, 0, 0};
      vecs[6]  = '{0, 0, 0,  5,  4,  3,  1,  0, 4, 0, 2}; // term, y latched
      vecs[7]  = '{0, 0, 1,  5,  4,  3,  0,  0, 4, 0, 3};
      vecs[8]  = '{1, 0, 0,  1,  0,  0,  0,  0, 0, 0, 0};
      vecs[9]  = '{0, 1, 0,  2,  1,  9,  0,  0, 0, 0, 1}; // step -> RUN
      vecs[10] = '{0, 1, 0,  3,  2,  9,  0,  0, 0, 0, 1};
      vecs[11] = '{0, 1, 0,  4,  2,  9,  0,  0, 0, 1, 1}; // y != x-1
      vecs[12] = '{0, 1, 0,  5,  4,  9,  0,  0, 0, 1, 1}; // sticky
      vecs[13] = '{0, 1, 0, 10,  9,  9,  1,  4, 9, 1, 2}; // 4 steps, term
      vecs[14] = '{1, 0, 0, 10,  9,  9,  0,  0, 0, 0, 0}; // rst mid-REPORT

      drive(1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0);
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].r, vecs[i].s, vecs[i].rdy, vecs[i].x, vecs[i].y, vecs[i].sz);
         tick();
         chk($sformatf("v%0d_valid", i),  done_valid,  vecs[i].e_valid);
         chk($sformatf("v%0d_cycles", i), done_cycles, vecs[i].e_cycles);
         chk($sformatf("v%0d_y", i),      done_y,      vecs[i].e_y);
         chk($sformatf("v%0d_inv", i),    inv_err,     vecs[i].e_inv);
         chk($sformatf("v%0d_state", i),  state_o,     vecs[i].e_state);
         chk($sformatf("v%0d_stall", i),  stall_flag,  0);
      end

      run_seq("plain", 1'b0, 0, 0);
      run_seq("hold5", 1'b0, 5, 0);
      run_seq("toggle", 1'b1, 0, 0);
      run_seq("jump", 1'b1, 2, 100);

      // Stall watchdog: one step into RUN, then selector low.
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 8'd230);
      tick();
      chk("stall_run", state_o, 1);
      drive(1'b0, 1'b0, 1'b0, 8'd2, 8'd1, 8'd230);
      for (int i = 0; i < 7; i++) tick();
      chk("stall_7_idle", stall_flag, 0);
      tick();
      chk("stall_8_idle", stall_flag, EXP_STALL);
      sel = 1'b1;
      tick();
      chk("stall_sticky", stall_flag, EXP_STALL);
      chk("stall_inv", inv_err, 0);
      do_reset();
      chk("stall_reset", stall_flag, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
